// File: rtl/risc_pkg.sv
// ----------------------------------------------------------------------------
// risc_pkg
// Shared types for the ALU result writeback stage.
//   wb_state_t  : writeback FSM states
//   wb_entry_t  : one buffered ALU result with its routing tags (71 bits)
//   REG_ZERO    : architectural zero register; writes to it are discarded
//   first_state : routing decision for an entry freshly popped from the queue
// ----------------------------------------------------------------------------
package risc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REG_WR = 2'd1,
      MEM_WR = 2'd2,
      DONE   = 2'd3
   } wb_state_t;

   typedef struct packed {
      logic [31:0] result;
      logic        reg_out;
      logic [4:0]  reg_addr;
      logic        mem_out;
      logic [31:0] mem_addr;
   } wb_entry_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Register write goes first; a register write aimed at x0 is skipped
   // entirely, and an entry with no live destination retires straight away.
   function automatic wb_state_t first_state(input wb_entry_t e);
      wb_state_t s;
      if (e.reg_out && (e.reg_addr != REG_ZERO)) begin
         s = REG_WR;
      end else if (e.mem_out) begin
         s = MEM_WR;
      end else begin
         s = DONE;
      end
      return s;
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// ----------------------------------------------------------------------------
// wb_result_fifo
// Small synchronous FIFO holding ALU results waiting for writeback.
// A push is refused while full, even if a pop happens on the same edge.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (flushes the queue)
//   push         : request to store push_data (ignored when full)
//   push_data    : entry to store
//   pop          : request to drop the head entry (ignored when empty)
//   pop_data     : current head entry (valid while !empty)
//   full, empty  : occupancy flags
// ----------------------------------------------------------------------------
module wb_result_fifo
   import risc_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output wb_entry_t pop_data,
   output logic      full,
   output logic      empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   wb_entry_t     storage_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (count_r == FULL_COUNT);
   assign empty     = (count_r == {CW{1'b0}});
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign pop_data  = storage_r[rd_ptr_r];

   // Entry storage; contents are don't-care until counted as occupied.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         storage_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_writeback.sv
// ----------------------------------------------------------------------------
// alu_result_writeback
// Writeback stage behind the ALU. Buffers each result with its routing tags,
// then commits it to the register file and/or memory, and pulses wb_done once
// per retired result (feeds the instruction handler's alu_done).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   alu_result[_valid], alu_reg_out/alu_reg_addr, alu_mem_out/alu_mem_addr
//                              : incoming result and its destinations
//   alu_result_ack             : result captured on this edge (valid && !full)
//   reg_wr_addr/data/valid     : register write request, held until reg_wr_ack
//   mem_wb_sel, mem_wr_addr/data, mem_rd_wr, mem_req_valid
//                              : memory write request, held until mem_ack or
//                                MEM_TIMEOUT cycles without an ack
//   wb_done                    : one-cycle pulse per retired entry
//   wb_error                   : sticky memory-timeout flag, cleared by reset
// ----------------------------------------------------------------------------
module alu_result_writeback
   import risc_pkg::*;
#(
   parameter int QUEUE_DEPTH = 2,
   parameter int MEM_TIMEOUT = 16
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] alu_result,
   input  logic        alu_result_valid,
   input  logic        alu_reg_out,
   input  logic [4:0]  alu_reg_addr,
   input  logic        alu_mem_out,
   input  logic [31:0] alu_mem_addr,
   output logic        alu_result_ack,
   output logic [4:0]  reg_wr_addr,
   output logic [31:0] reg_wr_data,
   output logic        reg_wr_valid,
   input  logic        reg_wr_ack,
   output logic        mem_wb_sel,
   output logic [31:0] mem_wr_addr,
   output logic [31:0] mem_wr_data,
   output logic        mem_rd_wr,
   output logic        mem_req_valid,
   input  logic        mem_ack,
   output logic        wb_done,
   output logic        wb_error
);

   localparam int TW = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

   wb_state_t   state_r;
   wb_state_t   idle_next_s;
   wb_entry_t   new_entry_s;
   wb_entry_t   head_s;
   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic        pop_s;

   // Working copy of the entry being retired.
   logic [31:0] work_data_r;
   logic [4:0]  work_reg_addr_r;
   logic [31:0] work_mem_addr_r;
   logic        work_mem_out_r;

   logic [TW-1:0] timer_r;

   logic [4:0]  reg_wr_addr_r;
   logic [31:0] reg_wr_data_r;
   logic        reg_wr_valid_r;
   logic        mem_wb_sel_r;
   logic [31:0] mem_wr_addr_r;
   logic [31:0] mem_wr_data_r;
   logic        mem_rd_wr_r;
   logic        mem_req_valid_r;
   logic        wb_done_r;
   logic        wb_error_r;

   assign alu_result_ack = alu_result_valid && !fifo_full_s;
   assign pop_s          = (state_r == IDLE) && !fifo_empty_s;

   assign reg_wr_addr    = reg_wr_addr_r;
   assign reg_wr_data    = reg_wr_data_r;
   assign reg_wr_valid   = reg_wr_valid_r;
   assign mem_wb_sel     = mem_wb_sel_r;
   assign mem_wr_addr    = mem_wr_addr_r;
   assign mem_wr_data    = mem_wr_data_r;
   assign mem_rd_wr      = mem_rd_wr_r;
   assign mem_req_valid  = mem_req_valid_r;
   assign wb_done        = wb_done_r;
   assign wb_error       = wb_error_r;

   // Pack the incoming result and tags into one queue entry.
   always_comb begin
      new_entry_s          = '0;
      new_entry_s.result   = alu_result;
      new_entry_s.reg_out  = alu_reg_out;
      new_entry_s.reg_addr = alu_reg_addr;
      new_entry_s.mem_out  = alu_mem_out;
      new_entry_s.mem_addr = alu_mem_addr;
   end

   // Routing decision for the head entry, used when it is popped.
   always_comb begin
      idle_next_s = IDLE;
      idle_next_s = first_state(head_s);
   end

   wb_result_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (alu_result_ack),
      .push_data (new_entry_s),
      .pop       (pop_s),
      .pop_data  (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Writeback FSM with registered request outputs. Each request is raised on
   // the first edge spent in its state and dropped on the edge that sees its
   // ack (or the timeout), so requests never overlap and wb_done is always
   // followed by at least one quiet cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= IDLE;
         work_data_r     <= 32'd0;
         work_reg_addr_r <= 5'd0;
         work_mem_addr_r <= 32'd0;
         work_mem_out_r  <= 1'b0;
         timer_r         <= {TW{1'b0}};
         reg_wr_addr_r   <= 5'd0;
         reg_wr_data_r   <= 32'd0;
         reg_wr_valid_r  <= 1'b0;
         mem_wb_sel_r    <= 1'b0;
         mem_wr_addr_r   <= 32'd0;
         mem_wr_data_r   <= 32'd0;
         mem_rd_wr_r     <= 1'b0;
         mem_req_valid_r <= 1'b0;
         wb_done_r       <= 1'b0;
         wb_error_r      <= 1'b0;
      end else begin
         wb_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!fifo_empty_s) begin
                  work_data_r     <= head_s.result;
                  work_reg_addr_r <= head_s.reg_addr;
                  work_mem_addr_r <= head_s.mem_addr;
                  work_mem_out_r  <= head_s.mem_out;
                  state_r         <= idle_next_s;
                  if (idle_next_s == DONE) begin
                     wb_done_r <= 1'b1;
                  end
               end
            end

            REG_WR: begin
               if (!reg_wr_valid_r) begin
                  reg_wr_valid_r <= 1'b1;
                  reg_wr_addr_r  <= work_reg_addr_r;
                  reg_wr_data_r  <= work_data_r;
               end else if (reg_wr_ack) begin
                  reg_wr_valid_r <= 1'b0;
                  if (work_mem_out_r) begin
                     state_r <= MEM_WR;
                  end else begin
                     state_r   <= DONE;
                     wb_done_r <= 1'b1;
                  end
               end
            end

            MEM_WR: begin
               if (!mem_req_valid_r) begin
                  mem_req_valid_r <= 1'b1;
                  mem_wb_sel_r    <= 1'b1;
                  mem_rd_wr_r     <= 1'b1;
                  mem_wr_addr_r   <= work_mem_addr_r;
                  mem_wr_data_r   <= work_data_r;
                  timer_r         <= {TW{1'b0}};
               end else if (mem_ack) begin
                  // An ack on the expiry cycle still counts as success.
                  mem_req_valid_r <= 1'b0;
                  mem_wb_sel_r    <= 1'b0;
                  mem_rd_wr_r     <= 1'b0;
                  state_r         <= DONE;
                  wb_done_r       <= 1'b1;
               end else if (timer_r == TIMER_LAST) begin
                  mem_req_valid_r <= 1'b0;
                  mem_wb_sel_r    <= 1'b0;
                  mem_rd_wr_r     <= 1'b0;
                  wb_error_r      <= 1'b1;
                  state_r         <= DONE;
                  wb_done_r       <= 1'b1;
               end else begin
                  timer_r <= timer_r + TIMER_ONE;
               end
            end

            DONE: begin
               state_r <= IDLE;
            end

            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_writeback.sv
// ----------------------------------------------------------------------------
// tb_alu_result_writeback
// Directed scoreboard bench: each issued result pushes its expected register
// write, memory write and wb_done events into a queue; a monitor pops and
// compares them as the DUT presents handshakes on its output ports.
// ----------------------------------------------------------------------------
module tb_alu_result_writeback;

   localparam int K_REG  = 0;
   localparam int K_MEM  = 1;
   localparam int K_DONE = 2;

   logic        clk;
   logic        reset;
   logic [31:0] alu_result;
   logic        alu_result_valid;
   logic        alu_reg_out;
   logic [4:0]  alu_reg_addr;
   logic        alu_mem_out;
   logic [31:0] alu_mem_addr;
   logic        alu_result_ack;
   logic [4:0]  reg_wr_addr;
   logic [31:0] reg_wr_data;
   logic        reg_wr_valid;
   logic        reg_wr_ack;
   logic        mem_wb_sel;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        mem_rd_wr;
   logic        mem_req_valid;
   logic        mem_ack;
   logic        wb_done;
   logic        wb_error;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      int          cycles;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic reg_ack_en;
   logic mem_ack_en;
   int   mem_delay;

   alu_result_writeback #(
      .QUEUE_DEPTH (2),
      .MEM_TIMEOUT (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .alu_result       (alu_result),
      .alu_result_valid (alu_result_valid),
      .alu_reg_out      (alu_reg_out),
      .alu_reg_addr     (alu_reg_addr),
      .alu_mem_out      (alu_mem_out),
      .alu_mem_addr     (alu_mem_addr),
      .alu_result_ack   (alu_result_ack),
      .reg_wr_addr      (reg_wr_addr),
      .reg_wr_data      (reg_wr_data),
      .reg_wr_valid     (reg_wr_valid),
      .reg_wr_ack       (reg_wr_ack),
      .mem_wb_sel       (mem_wb_sel),
      .mem_wr_addr      (mem_wr_addr),
      .mem_wr_data      (mem_wr_data),
      .mem_rd_wr        (mem_rd_wr),
      .mem_req_valid    (mem_req_valid),
      .mem_ack          (mem_ack),
      .wb_done          (wb_done),
      .wb_error         (wb_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic take_exp(input int kind, output exp_t e, output bit ok);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         ok = 1'b0;
         $display("FAIL unexpected_event: actual kind=%0d required no event", kind);
      end else begin
         e  = exp_q.pop_front();
         ok = 1'b1;
         chk("event_kind", 64'(kind), 64'(e.kind));
      end
   endtask

   task automatic expect_ev(input int kind, input logic [31:0] addr, input logic [31:0] data,
                            input int cyc, input logic err);
      exp_t e;
      e.kind   = kind;
      e.addr   = addr;
      e.data   = data;
      e.cycles = cyc;
      e.err    = err;
      exp_q.push_back(e);
   endtask

   // Responder: acks driven 1 time unit after each rising edge.
   initial begin
      int mcnt;
      mcnt       = 0;
      reg_wr_ack = 1'b0;
      mem_ack    = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req_valid) mcnt++;
         else mcnt = 0;
         reg_wr_ack = reg_ack_en && reg_wr_valid;
         mem_ack    = mem_ack_en && mem_req_valid && (mcnt > mem_delay);
      end
   end

   // Monitor: samples on the falling edge and checks against the scoreboard.
   initial begin
      exp_t        e;
      bit          ok;
      logic        prev_mv;
      logic        prev_done;
      int          mv_cycles;
      logic [31:0] last_addr;
      logic [31:0] last_data;
      logic [1:0]  last_ctl;
      prev_mv   = 1'b0;
      prev_done = 1'b0;
      mv_cycles = 0;
      last_addr = 32'd0;
      last_data = 32'd0;
      last_ctl  = 2'b00;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_mv   = 1'b0;
            prev_done = 1'b0;
            mv_cycles = 0;
         end else begin
            if (reg_wr_valid && reg_wr_ack) begin
               take_exp(K_REG, e, ok);
               if (ok) begin
                  chk("reg_wr_addr", 64'(reg_wr_addr), 64'(e.addr[4:0]));
                  chk("reg_wr_data", 64'(reg_wr_data), 64'(e.data));
               end
            end
            if (mem_req_valid) begin
               mv_cycles++;
               last_addr = mem_wr_addr;
               last_data = mem_wr_data;
               last_ctl  = {mem_wb_sel, mem_rd_wr};
            end else if (prev_mv) begin
               take_exp(K_MEM, e, ok);
               if (ok) begin
                  chk("mem_wr_addr", 64'(last_addr), 64'(e.addr));
                  chk("mem_wr_data", 64'(last_data), 64'(e.data));
                  chk("mem_sel_rdwr", 64'(last_ctl), 64'd3);
                  chk("mem_req_cycles", 64'(mv_cycles), 64'(e.cycles));
                  chk("wb_error", 64'(wb_error), 64'(e.err));
               end
               mv_cycles = 0;
            end
            prev_mv = mem_req_valid;
            if (wb_done) begin
               take_exp(K_DONE, e, ok);
               chk("wb_done_pulse", 64'(prev_done), 64'd0);
            end
            prev_done = wb_done;
         end
      end
   end

   // Called at rise+2: drive one result and check the combinational ack.
   task automatic present(input logic [31:0] res, input logic ro, input logic [4:0] ra,
                          input logic mo, input logic [31:0] ma, input logic exp_ack,
                          input string nm);
      alu_result       = res;
      alu_reg_out      = ro;
      alu_reg_addr     = ra;
      alu_mem_out      = mo;
      alu_mem_addr     = ma;
      alu_result_valid = 1'b1;
      #1;
      chk({nm, "_ack"}, 64'(alu_result_ack), 64'(exp_ack));
   endtask

   // Hold valid until accepted, pass the capture edge, return at rise+2.
   task automatic commit(input string nm);
      int guard;
      guard = 0;
      while (!alu_result_ack && guard < 200) begin
         @(posedge clk);
         #3;
         guard++;
      end
      chk({nm, "_accepted"}, 64'(alu_result_ack), 64'd1);
      @(posedge clk);
      #2;
      alu_result_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drain(input string nm);
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 400) begin
         @(posedge clk);
         g++;
      end
      #2;
      chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
      idle(3);
   endtask

   initial begin
      reset            = 1'b1;
      alu_result       = 32'd0;
      alu_result_valid = 1'b0;
      alu_reg_out      = 1'b0;
      alu_reg_addr     = 5'd0;
      alu_mem_out      = 1'b0;
      alu_mem_addr     = 32'd0;
      reg_ack_en       = 1'b1;
      mem_ack_en       = 1'b1;
      mem_delay        = 0;

      // Reset state
      idle(3);
      chk("rst_reg_wr_valid", 64'(reg_wr_valid), 64'd0);
      chk("rst_reg_wr_addr_data", {27'd0, reg_wr_addr, reg_wr_data}, 64'd0);
      chk("rst_mem_ctl", {60'd0, mem_wb_sel, mem_rd_wr, mem_req_valid, wb_done}, 64'd0);
      chk("rst_mem_addr_data", {mem_wr_addr, mem_wr_data}, 64'd0);
      chk("rst_wb_error", 64'(wb_error), 64'd0);
      reset = 1'b0;
      idle(1);

      // 1: register-only write with immediate ack, latency checked
      present(32'h0000_0005, 1'b1, 5'd3, 1'b0, 32'd0, 1'b1, "t1");
      expect_ev(K_REG, 32'd3, 32'h0000_0005, 0, 1'b0);
      expect_ev(K_DONE, 32'd0, 32'd0, 0, 1'b0);
      commit("t1");
      idle(1);
      chk("t1_valid_n1", 64'(reg_wr_valid), 64'd0);
      idle(1);
      chk("t1_valid_n2", 64'(reg_wr_valid), 64'd1);
      chk("t1_addr_n2", 64'(reg_wr_addr), 64'd3);
      idle(1);
      chk("t1_done_n3", 64'(wb_done), 64'd1);
      chk("t1_valid_n3", 64'(reg_wr_valid), 64'd0);
      idle(1);
      chk("t1_done_n4", 64'(wb_done), 64'd0);
      drain("t1");

      // 2: write to x0 is dropped but still retires
      present(32'h0000_1234, 1'b1, 5'd0, 1'b0, 32'd0, 1'b1, "t2");
      expect_ev(K_DONE, 32'd0, 32'd0, 0, 1'b0);
      commit("t2");
      drain("t2");

      // 3: register then memory, memory acked 3 cycles late
      mem_delay = 3;
      present(32'hCAFE_F00D, 1'b1, 5'd7, 1'b1, 32'h0000_0040, 1'b1, "t3");
      expect_ev(K_REG, 32'd7, 32'hCAFE_F00D, 0, 1'b0);
      expect_ev(K_MEM, 32'h0000_0040, 32'hCAFE_F00D, 4, 1'b0);
      expect_ev(K_DONE, 32'd0, 32'd0, 0, 1'b0);
      commit("t3");
      drain("t3");
      mem_delay = 0;

      // 4: backpressure; one entry in flight plus two queued, the next is refused
      reg_ack_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         present(32'h0000_0100 + 32'(i), 1'b1, 5'(10 + i), 1'b0, 32'd0, 1'b1,
                 $sformatf("t4_%0d", i));
         expect_ev(K_REG, 32'(10 + i), 32'h0000_0100 + 32'(i), 0, 1'b0);
         expect_ev(K_DONE, 32'd0, 32'd0, 0, 1'b0);
         commit($sformatf("t4_%0d", i));
      end
      present(32'h0000_0103, 1'b1, 5'd13, 1'b0, 32'd0, 1'b0, "t4_full");
      expect_ev(K_REG, 32'd13, 32'h0000_0103, 0, 1'b0);
      expect_ev(K_DONE, 32'd0, 32'd0, 0, 1'b0);
      reg_ack_en = 1'b1;
      commit("t4_full");
      drain("t4");

      // 5: memory write never acked -> timeout, sticky error
      mem_ack_en = 1'b0;
      present(32'h0BAD_0BAD, 1'b0, 5'd0, 1'b1, 32'h0000_0080, 1'b1, "t5");
      expect_ev(K_MEM, 32'h0000_0080, 32'h0BAD_0BAD, 16, 1'b1);
      expect_ev(K_DONE, 32'd0, 32'd0, 0, 1'b0);
      commit("t5");
      drain("t5");
      chk("t5_error_sticky", 64'(wb_error), 64'd1);
      chk("t5_req_dropped", 64'(mem_req_valid), 64'd0);

      // 6: reset during a memory write with two entries queued
      present(32'h0000_000A, 1'b0, 5'd0, 1'b1, 32'h0000_0100, 1'b1, "t6_a");
      commit("t6_a");
      present(32'h0000_000B, 1'b1, 5'd5, 1'b0, 32'd0, 1'b1, "t6_b");
      commit("t6_b");
      present(32'h0000_000C, 1'b1, 5'd6, 1'b0, 32'd0, 1'b1, "t6_c");
      commit("t6_c");
      idle(3);
      chk("t6_in_mem_wr", 64'(mem_req_valid), 64'd1);
      reset = 1'b1;
      exp_q.delete();
      idle(1);
      chk("t6_rst_ctl", {59'd0, reg_wr_valid, mem_wb_sel, mem_rd_wr, mem_req_valid, wb_done}, 64'd0);
      chk("t6_rst_error", 64'(wb_error), 64'd0);
      reset      = 1'b0;
      mem_ack_en = 1'b1;
      idle(30);
      chk("t6_quiet_reg", 64'(reg_wr_valid), 64'd0);
      chk("t6_quiet_mem", 64'(mem_req_valid), 64'd0);

      // 7: recovery after reset, dual write to reg 31 and top memory word
      present(32'h0000_0077, 1'b1, 5'd31, 1'b1, 32'hFFFF_FFFC, 1'b1, "t7");
      expect_ev(K_REG, 32'd31, 32'h0000_0077, 0, 1'b0);
      expect_ev(K_MEM, 32'hFFFF_FFFC, 32'h0000_0077, 1, 1'b0);
      expect_ev(K_DONE, 32'd0, 32'd0, 0, 1'b0);
      commit("t7");
      drain("t7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
